bcd_counter: RTL and testbench



---
 rtl/bcd_pkg.sv | 13 +
 rtl/bcd_digit.sv | 40 ++++
 rtl/bcd_counter.sv | 91 +++++++++
 tb/tb_bcd_counter.sv | 146 ++++++++++++++
 4 files changed

// File: rtl/bcd_pkg.sv
// Shared BCD digit type and digit limits for the BCD counter slice.
// Latency: none (definitions only).
// Backpressure: not applicable.
package bcd_pkg;

  localparam int DIGIT_W = 4;

  typedef logic [DIGIT_W-1:0] bcd_digit_t;

  localparam bcd_digit_t BCD_MAX = 4'd9;
  localparam bcd_digit_t BCD_MIN = 4'd0;

endpackage : bcd_pkg

// File: rtl/bcd_digit.sv
// Single BCD digit step: +/-1 when cin is set, with carry/borrow out at 9/0.
// Latency: combinational, zero cycles.
// Backpressure: none; a digit above 9 is treated as 0 before stepping.
module bcd_digit
  import bcd_pkg::*;
(
  input  bcd_digit_t digit,
  input  logic       up,
  input  logic       cin,
  output bcd_digit_t digit_next,
  output logic       cout
);

  bcd_digit_t digit_clean;

  // Sanitise the digit, then step it up or down when the chain below asks.
  always_comb begin
    digit_clean = (digit > BCD_MAX) ? BCD_MIN : digit;
    digit_next  = digit_clean;
    cout        = 1'b0;
    if (cin) begin
      if (up) begin
        if (digit_clean == BCD_MAX) begin
          digit_next = BCD_MIN;
          cout       = 1'b1;
        end else begin
          digit_next = digit_clean + 4'd1;
        end
      end else begin
        if (digit_clean == BCD_MIN) begin
          digit_next = BCD_MAX;
          cout       = 1'b1;
        end else begin
          digit_next = digit_clean - 4'd1;
        end
      end
    end
  end

endmodule : bcd_digit

// File: rtl/bcd_counter.sv
// N-digit BCD up/down counter with clear/load/enable; BCD_COUNTER_SAT_EN selects saturation.
// Latency: count, carry_out and load_err update one cycle after the qualifying edge.
// Backpressure: none; priority clr > load > en, one step per enabled cycle.
module bcd_counter
  import bcd_pkg::*;
#(
  parameter int                      N_DIGITS  = 3,
  parameter logic [4*N_DIGITS-1:0]   RESET_VAL = '0
) (
  input  logic                    clk,
  input  logic                    rst_n,
  input  logic                    clr,
  input  logic                    load,
  input  logic [4*N_DIGITS-1:0]   load_val,
  input  logic                    en,
  input  logic                    up,
  output logic [4*N_DIGITS-1:0]   count,
  output logic                    carry_out,
  output logic                    load_err
);

  localparam int W = DIGIT_W * N_DIGITS;

  logic [W-1:0]      step_val;
  logic [N_DIGITS:0] chain;
  logic              wrap;
  logic [W-1:0]      load_clean;
  logic              load_bad;

  // Digit 0 always receives the step; the chain ripples within one cycle.
  assign chain[0] = 1'b1;
  assign wrap     = chain[N_DIGITS];

  genvar g;
  generate
    for (g = 0; g < N_DIGITS; g++) begin : g_digit
      bcd_digit u_digit (
        .digit      (count[DIGIT_W*g +: DIGIT_W]),
        .up         (up),
        .cin        (chain[g]),
        .digit_next (step_val[DIGIT_W*g +: DIGIT_W]),
        .cout       (chain[g+1])
      );
    end
  endgenerate

  // Replace any non-BCD nibble of the load value with 0 and flag it.
  always_comb begin
    load_clean = load_val;
    load_bad   = 1'b0;
    for (int i = 0; i < N_DIGITS; i++) begin
      if (load_val[DIGIT_W*i +: DIGIT_W] > BCD_MAX) begin
        load_clean[DIGIT_W*i +: DIGIT_W] = BCD_MIN;
        load_bad                         = 1'b1;
      end
    end
  end

  // Counter state with clr > load > en priority; carry_out is a one-cycle pulse.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      count     <= RESET_VAL;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else if (clr) begin
      count     <= RESET_VAL;
      carry_out <= 1'b0;
      load_err  <= 1'b0;
    end else if (load) begin
      count     <= load_clean;
      carry_out <= 1'b0;
      if (load_bad) begin
        load_err <= 1'b1;
      end
    end else if (en) begin
`ifdef BCD_COUNTER_SAT_EN
      // At the limit the value holds and carry_out marks the overflow/underflow.
      if (!wrap) begin
        count <= step_val;
      end
      carry_out <= wrap;
`else
      count     <= step_val;
      carry_out <= wrap;
`endif
    end else begin
      carry_out <= 1'b0;
    end
  end

endmodule : bcd_counter

// File: tb/tb_bcd_counter.sv
// Directed self-checking bench for bcd_counter (N_DIGITS=3, RESET_VAL=0).
// Latency: samples outputs 1 time unit after each rising clock edge.
// Backpressure: not applicable; BCD_COUNTER_SAT_EN switches limit expectations.
module tb_bcd_counter;

  logic        clk;
  logic        rst_n;
  logic        clr;
  logic        load;
  logic [11:0] load_val;
  logic        en;
  logic        up;
  logic [11:0] count;
  logic        carry_out;
  logic        load_err;

  int checks   = 0;
  int failures = 0;

`ifdef BCD_COUNTER_SAT_EN
  localparam logic [11:0] UP_LIMIT_VAL = 12'h999;
  localparam logic [11:0] DN_LIMIT_VAL = 12'h000;
`else
  localparam logic [11:0] UP_LIMIT_VAL = 12'h000;
  localparam logic [11:0] DN_LIMIT_VAL = 12'h999;
`endif

  bcd_counter #(
    .N_DIGITS  (3),
    .RESET_VAL (12'h000)
  ) dut (
    .clk       (clk),
    .rst_n     (rst_n),
    .clr       (clr),
    .load      (load),
    .load_val  (load_val),
    .en        (en),
    .up        (up),
    .count     (count),
    .carry_out (carry_out),
    .load_err  (load_err)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", tag, act, exp);
    end
  endtask

  // Apply one set of controls across a rising edge, then settle before sampling.
  task automatic cyc(input logic c, input logic l, input logic [11:0] lv,
                     input logic e, input logic u);
    clr      = c;
    load     = l;
    load_val = lv;
    en       = e;
    up       = u;
    @(posedge clk);
    #1;
  endtask

  initial begin
    rst_n = 1'b0; clr = 1'b0; load = 1'b0; load_val = '0; en = 1'b0; up = 1'b1;
    @(posedge clk); #1;
    check("rst_count", 32'(count), 32'h000);
    check("rst_carry", 32'(carry_out), 32'h0);
    check("rst_err",   32'(load_err), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Async reset mid-count
    cyc(0, 1, 12'h257, 0, 1);
    check("load_257", 32'(count), 32'h257);
    clr = 0; load = 0; en = 1; up = 1;
    #2 rst_n = 1'b0;
    #1;
    check("async_rst_count", 32'(count), 32'h000);
    check("async_rst_carry", 32'(carry_out), 32'h0);
    @(negedge clk);
    rst_n = 1'b1;

    // Up ripple
    cyc(0, 1, 12'h259, 0, 1);
    cyc(0, 0, 12'h000, 1, 1);
    check("up_259", 32'(count), 32'h260);
    check("up_259_carry", 32'(carry_out), 32'h0);
    cyc(0, 1, 12'h099, 0, 1);
    cyc(0, 0, 12'h000, 1, 1);
    check("up_099", 32'(count), 32'h100);

    // Up wrap at all nines
    cyc(0, 1, 12'h999, 0, 1);
    check("load_999_carry", 32'(carry_out), 32'h0);
    cyc(0, 0, 12'h000, 1, 1);
    check("up_wrap_count", 32'(count), 32'(UP_LIMIT_VAL));
    check("up_wrap_carry", 32'(carry_out), 32'h1);
    cyc(0, 0, 12'h000, 0, 1);
    check("up_wrap_carry_once", 32'(carry_out), 32'h0);
    check("hold_count", 32'(count), 32'(UP_LIMIT_VAL));

    // Down borrow
    cyc(0, 1, 12'h300, 0, 0);
    cyc(0, 0, 12'h000, 1, 0);
    check("dn_300", 32'(count), 32'h299);
    check("dn_300_carry", 32'(carry_out), 32'h0);
    cyc(0, 0, 12'h000, 1, 1);
    check("dir_change_up", 32'(count), 32'h300);
    cyc(0, 1, 12'h000, 0, 0);
    cyc(0, 0, 12'h000, 1, 0);
    check("dn_wrap_count", 32'(count), 32'(DN_LIMIT_VAL));
    check("dn_wrap_carry", 32'(carry_out), 32'h1);
    cyc(0, 0, 12'h000, 0, 0);
    check("dn_wrap_carry_once", 32'(carry_out), 32'h0);

    // Priority
    cyc(0, 1, 12'h123, 0, 1);
    check("load_123", 32'(count), 32'h123);
    cyc(1, 1, 12'h777, 1, 1);
    check("prio_clr", 32'(count), 32'h000);
    check("prio_clr_carry", 32'(carry_out), 32'h0);
    cyc(0, 1, 12'h456, 1, 1);
    check("prio_load", 32'(count), 32'h456);
    check("valid_load_err", 32'(load_err), 32'h0);

    // Invalid load
    cyc(0, 1, 12'h1A3, 0, 1);
    check("bad_load_count", 32'(count), 32'h103);
    check("bad_load_err", 32'(load_err), 32'h1);
    cyc(0, 1, 12'h456, 0, 1);
    check("sticky_err", 32'(load_err), 32'h1);
    check("sticky_count", 32'(count), 32'h456);
    cyc(0, 1, 12'hF0B, 0, 1);
    check("bad_hi_lo", 32'(count), 32'h000);
    cyc(1, 0, 12'h000, 0, 1);
    check("clr_err", 32'(load_err), 32'h0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule : tb_bcd_counter
